// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Build option: define SB_FORWARD_EN to forward buffered stores to loads.
package dmem_pkg;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    localparam int IDX_W = 30;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
    } lane_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
        logic [3:0]       mask;
    } sb_entry_t;

    function automatic logic [2:0] norm_dmtype(input logic [2:0] t);
        return (t > DM_BU) ? DM_W : t;
    endfunction

    function automatic logic is_aligned(
        input logic [2:0] t,
        input logic [1:0] a
    );
        logic ok;
        unique case (1'b1)
            (t == DM_H), (t == DM_HU): ok = ~a[0];
            (t == DM_B), (t == DM_BU): ok = 1'b1;
            default:                   ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic lane_t store_lane(
        input logic [2:0]  t,
        input logic [1:0]  a,
        input logic [31:0] d
    );
        lane_t l;
        unique case (1'b1)
            (t == DM_H), (t == DM_HU): begin
                l.data = a[1] ? {d[15:0], 16'h0} : {16'h0, d[15:0]};
                l.mask = a[1] ? 4'b1100 : 4'b0011;
            end
            (t == DM_B), (t == DM_BU): begin
                l.data = {24'h0, d[7:0]} << {a, 3'b000};
                l.mask = 4'b0001 << a;
            end
            default: begin
                l.data = d;
                l.mask = 4'b1111;
            end
        endcase
        return l;
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [2:0]  t,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? w[31:16] : w[15:0];
        b = 8'(w >> {a, 3'b000});
        unique case (1'b1)
            (t == DM_H):  r = {{16{h[15]}}, h};
            (t == DM_HU): r = {16'h0, h};
            (t == DM_B):  r = {{24{b[7]}}, b};
            (t == DM_BU): r = {24'h0, b};
            default:      r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sb_fifo.sv
// Circular store-buffer FIFO; entries are exposed in age order,
// slot 0 being the oldest (head) entry.
module dmem_sb_fifo
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  sb_entry_t             push_entry,
    input  logic                  pop,
    output sb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      valid,
    output logic [PW:0]           count
);

    sb_entry_t [DEPTH-1:0] slots;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic push_ok;
    logic pop_ok;

    assign push_ok = push && (count != (PW+1)'(DEPTH));
    assign pop_ok  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + PW'(1);
            if (pop_ok)  head <= head + PW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) slots[tail] <= push_entry;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = slots[head + PW'(i)];
            valid[i]   = (PW+1)'(i) < count;
        end
    end

endmodule

// File: rtl/dmem_store_buffer_responder.sv
// Data-port responder: word RAM behind an in-order store buffer.
// Define SB_FORWARD_EN to forward buffered bytes instead of stalling loads.
module dmem_store_buffer_responder
    import dmem_pkg::*;
#(
    parameter  int RAM_AW   = 10,
    parameter  int SB_DEPTH = 4,
    localparam int CW       = $clog2(SB_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic          req_we,
    input  logic          req_re,
    input  logic [2:0]    req_dmtype,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          misalign,
    output logic [CW-1:0] sb_count
);

    logic [31:0] ram [2**RAM_AW];

    sb_entry_t [SB_DEPTH-1:0] entries;
    logic [SB_DEPTH-1:0] valid;
    logic [CW-1:0]       count;
    logic [RAM_AW-1:0]   widx;
    logic [RAM_AW-1:0]   drain_idx;
    logic [2:0]          dmt;
    logic [31:0]         ram_word;
    logic [31:0]         load_src;
    sb_entry_t           new_entry;
    lane_t               lane;
    logic aligned;
    logic do_store;
    logic do_load;
    logic load_stall;
    logic port_busy;
    logic full;
    logic push;
    logic pop;
    logic addr_unused;

    assign widx        = req_addr[RAM_AW+1:2];
    assign addr_unused = ^req_addr[31:RAM_AW+2];
    assign dmt         = norm_dmtype(req_dmtype);
    assign aligned     = is_aligned(dmt, req_addr[1:0]);
    assign do_store    = rst && req_we && aligned;
    assign do_load     = rst && req_re && !req_we && aligned;
    assign full        = (count == CW'(SB_DEPTH));
    assign lane        = store_lane(dmt, req_addr[1:0], req_wdata);
    assign ram_word    = ram[widx];

    assign new_entry = '{
        idx:  IDX_W'(widx),
        data: lane.data,
        mask: lane.mask
    };

`ifdef SB_FORWARD_EN
    // Oldest to youngest, so younger bytes overwrite older ones.
    always_comb begin
        load_src = ram_word;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid[i] && entries[i].idx == IDX_W'(widx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[i].mask[b])
                        load_src[8*b +: 8] = entries[i].data[8*b +: 8];
                end
            end
        end
    end
    assign load_stall = 1'b0;
`else
    logic hit;
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid[i] && entries[i].idx == IDX_W'(widx))
                hit = 1'b1;
        end
    end
    assign load_src   = ram_word;
    assign load_stall = do_load && hit;
`endif

    // A stalled load leaves the port to the drain so the hazard clears.
    assign port_busy = rst && req_re && aligned && !load_stall;
    assign push      = do_store && !full;
    assign pop       = rst && (count != '0) && !port_busy;

    assign stall     = (do_store && full) || load_stall;
    assign misalign  = rst && (req_we || req_re) && !aligned;
    assign sb_count  = rst ? count : '0;
    assign rdata     = (do_load && !load_stall)
                     ? load_extend(dmt, req_addr[1:0], load_src)
                     : 32'h0;

    dmem_sb_fifo #(
        .DEPTH(SB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .entries    (entries),
        .valid      (valid),
        .count      (count)
    );

    assign drain_idx = entries[0].idx[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (pop) begin
            for (int b = 0; b < 4; b++) begin
                if (entries[0].mask[b])
                    ram[drain_idx][8*b +: 8] <= entries[0].data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer_responder.sv
// Scoreboard bench for dmem_store_buffer_responder.
// Negedge monitor plus direct checks.
module tb_dmem_store_buffer_responder;

  localparam logic [2:0] W  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] HU = 3'b010;
  localparam logic [2:0] B  = 3'b011;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] X7 = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic        req_re = 1'b0;
  logic [2:0]  req_dmtype = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic [2:0]  sb_count;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        st;
    logic        mi;
    int          cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  dmem_store_buffer_responder #(
    .RAM_AW   (10),
    .SB_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_re     (req_re),
    .req_dmtype (req_dmtype),
    .rdata      (rdata),
    .stall      (stall),
    .misalign   (misalign),
    .sb_count   (sb_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_total++;
      if (rdata === e.rd && stall === e.st &&
          misalign === e.mi &&
          int'(sb_count) === e.cnt)
        n_pass++;
      else
        $display("FAIL %s: rd=%h st=%b mi=%b c=%0d want %h %b %b %0d",
                 e.name, rdata, stall, misalign, sb_count,
                 e.rd, e.st, e.mi, e.cnt);
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] rd,
    input logic        st,
    input logic        mi,
    input int          cnt
  );
    n_total++;
    if (rdata !== rd || stall !== st ||
        misalign !== mi ||
        int'(sb_count) !== cnt)
      $display("FAIL %s: rd=%h st=%b mi=%b c=%0d want %h %b %b %0d",
               nm, rdata, stall, misalign, sb_count,
               rd, st, mi, cnt);
    else
      n_pass++;
  endtask

  task automatic cyc(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic        we,
    input logic        re,
    input logic [2:0]  t,
    input string       nm,
    input logic [31:0] rd,
    input logic        st,
    input logic        mi,
    input int          cnt
  );
    exp_t e;
    req_addr   = a;
    req_wdata  = d;
    req_we     = we;
    req_re     = re;
    req_dmtype = t;
    e.name = nm;
    e.rd   = rd;
    e.st   = st;
    e.mi   = mi;
    e.cnt  = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input int cnt);
    cyc(32'h0, 32'h0, 1'b0, 1'b0, W, nm,
        32'h0, 1'b0, 1'b0, cnt);
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(32'h13, 0, 0, 1, W, "rst_a", 0, 0, 0, 0);
    cyc(32'h13, 0, 0, 1, W, "rst_b", 0, 0, 0, 0);
    chk("rst_state", 0, 0, 0, 0);
    rst = 1'b1;

    cyc(32'h10, 32'hDEADBEEF, 1, 0, W, "sw_10", 0, 0, 0, 0);
    idle("drain_10", 1);
    idle("empty_10", 0);
    cyc(32'h10, 0, 0, 1, W, "lw_10", 32'hDEADBEEF, 0, 0, 0);

    cyc(32'h20, 32'h11223344, 1, 0, W, "sw_20", 0, 0, 0, 0);
    cyc(32'h21, 32'h80, 1, 0, B, "sb_21", 0, 0, 0, 1);
    idle("drain_21", 1);
    cyc(32'h21, 0, 0, 1, B,  "lb_21",  32'hFFFFFF80, 0, 0, 0);
    cyc(32'h21, 0, 0, 1, BU, "lbu_21", 32'h00000080, 0, 0, 0);
    cyc(32'h20, 0, 0, 1, W,  "lw_20",  32'h11228044, 0, 0, 0);
    cyc(32'h22, 0, 0, 1, H,  "lh_22",  32'h00001122, 0, 0, 0);
    cyc(32'h20, 0, 0, 1, H,  "lh_20",  32'hFFFF8044, 0, 0, 0);
    cyc(32'h20, 0, 0, 1, HU, "lhu_20", 32'h00008044, 0, 0, 0);

    cyc(32'h100, 32'hA0, 1, 1, W, "fill0", 0, 0, 0, 0);
    cyc(32'h104, 32'hA1, 1, 1, W, "fill1", 0, 0, 0, 1);
    cyc(32'h108, 32'hA2, 1, 1, W, "fill2", 0, 0, 0, 2);
    cyc(32'h10C, 32'hA3, 1, 1, W, "fill3", 0, 0, 0, 3);
    cyc(32'h110, 32'hA4, 1, 1, W, "full", 0, 1, 0, 4);
    cyc(32'h110, 32'hA4, 1, 0, W, "full_drain", 0, 1, 0, 4);
    cyc(32'h110, 32'hA4, 1, 1, W, "enq_after", 0, 0, 0, 3);
    cyc(32'h10, 0, 0, 1, W, "lw_unrel", 32'hDEADBEEF, 0, 0, 4);
    idle("drn4", 4);
    idle("drn3", 3);
    idle("drn2", 2);
    idle("drn1", 1);
    cyc(32'h110, 0, 0, 1, W, "lw_110", 32'hA4, 0, 0, 0);
    cyc(32'h100, 0, 0, 1, W, "lw_100", 32'hA0, 0, 0, 0);

    cyc(32'h40, 32'h11223344, 1, 0, W, "sw_40", 0, 0, 0, 0);
`ifdef SB_FORWARD_EN
    cyc(32'h40, 0, 0, 1, W, "lw_40_fwd", 32'h11223344, 0, 0, 1);
    chk("expire_fwd", 32'h11223344, 0, 0, 1);
    idle("drn_40", 1);
`else
    cyc(32'h40, 0, 0, 1, W, "lw_40_haz", 0, 1, 0, 1);
    chk("expire_haz", 32'h11223344, 0, 0, 0);
    cyc(32'h40, 0, 0, 1, W, "lw_40", 32'h11223344, 0, 0, 0);
`endif
    cyc(32'h40, 32'h55667788, 1, 1, W, "sw_40b", 0, 0, 0, 0);
    cyc(32'h41, 32'hEE, 1, 1, B, "sb_41", 0, 0, 0, 1);
`ifdef SB_FORWARD_EN
    cyc(32'h40, 0, 0, 1, W, "lw_merge", 32'h5566EE88, 0, 0, 2);
    idle("drn_m2", 2);
    idle("drn_m1", 1);
`else
    cyc(32'h40, 0, 0, 1, W, "lw_haz2", 0, 1, 0, 2);
    cyc(32'h40, 0, 0, 1, W, "lw_haz1", 0, 1, 0, 1);
    cyc(32'h40, 0, 0, 1, W, "lw_merge", 32'h5566EE88, 0, 0, 0);
`endif
    cyc(32'h40, 0, 0, 1, W, "lw_40_ram", 32'h5566EE88, 0, 0, 0);

    cyc(32'h13, 0, 0, 1, H, "lh_13", 0, 0, 1, 0);
    cyc(32'h22, 32'h99, 1, 0, W, "sw_22", 0, 0, 1, 0);
    idle("after_mis", 0);
    cyc(32'h20, 0, 0, 1, W,  "lw_20_kept", 32'h11228044, 0, 0, 0);
    cyc(32'h12, 0, 0, 1, X7, "lw7_12", 0, 0, 1, 0);
    cyc(32'h10, 0, 0, 1, X7, "lw7_10", 32'hDEADBEEF, 0, 0, 0);

    cyc(32'h200, 32'h0A0A0A0A, 1, 0, W, "pre0", 0, 0, 0, 0);
    cyc(32'h204, 32'h0B0B0B0B, 1, 0, W, "pre1", 0, 0, 0, 1);
    cyc(32'h208, 32'h0C0C0C0C, 1, 0, W, "pre2", 0, 0, 0, 1);
    idle("pre_drn", 1);
    cyc(32'h200, 32'hF0F0F0F0, 1, 1, W, "pend0", 0, 0, 0, 0);
    cyc(32'h204, 32'hF1F1F1F1, 1, 1, W, "pend1", 0, 0, 0, 1);
    cyc(32'h208, 32'hF2F2F2F2, 1, 1, W, "pend2", 0, 0, 0, 2);
    cyc(32'h10, 0, 0, 1, W, "pend_hold", 32'hDEADBEEF, 0, 0, 3);
    rst = 1'b0;
    cyc(32'h10, 0, 0, 1, W, "in_rst", 0, 0, 0, 0);
    rst = 1'b1;
    cyc(32'h200, 0, 0, 1, W, "lw_200", 32'h0A0A0A0A, 0, 0, 0);
    cyc(32'h204, 0, 0, 1, W, "lw_204", 32'h0B0B0B0B, 0, 0, 0);
    cyc(32'h208, 0, 0, 1, W, "lw_208", 32'h0C0C0C0C, 0, 0, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
